// File: rtl/reg_scoreboard.sv
// Per-GPR scoreboard for in-flight long-latency writes (loads, CSR reads, mul/div).
// Produces the combinational ID-stage issue stall with a same-cycle release bypass.
module reg_scoreboard #(
  parameter int NREG   = 32,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic              aclk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic              issue_fire,
  input  logic              issue_long,
  input  logic [4:0]        issue_rd,
  input  logic              use_rj,
  input  logic              use_rk,
  input  logic              use_rd,
  input  logic [4:0]        rj_no,
  input  logic [4:0]        rk_no,
  input  logic [4:0]        rd_no,
  input  logic              rel_valid,
  input  logic [4:0]        rel_rd,
  output logic              stall,
  output logic [NREG-1:0]   busy_vec,
  output logic [PERF_W-1:0] stall_cycles,
  output logic              err_underflow
);

  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic              alloc_s;
  logic              rel_s;
  logic [CNT_W-1:0]  cnt_s [NREG];
  logic [NREG-1:0]   busy_nxt_s;
  logic [NREG-1:0]   busy_vec_r;
  logic              stall_s;
  logic              sat_s;
  logic              underflow_s;
  logic [PERF_W-1:0] stall_cycles_r;
  logic              err_underflow_r;

  // A register is still busy unless its last outstanding write releases this cycle.
  function automatic logic eff_busy(input logic [CNT_W-1:0] cnt, input logic bypass);
    return (cnt != CNT_ZERO) && !(bypass && (cnt == CNT_ONE));
  endfunction

  assign alloc_s = issue_fire && issue_long && (issue_rd != 5'd0) && !flush;
  assign rel_s   = rel_valid && (rel_rd != 5'd0) && !flush;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign cnt_s[i]      = CNT_ZERO;
      assign busy_nxt_s[i] = 1'b0;
    end else begin : g_cnt
      logic             hit_alloc_s;
      logic             hit_rel_s;
      logic [CNT_W-1:0] cnt_r;
      logic [CNT_W-1:0] cnt_nxt_s;

      assign hit_alloc_s = alloc_s && (issue_rd == 5'(i));
      assign hit_rel_s   = rel_s && (rel_rd == 5'(i));

      // Next pending count: saturate at max, floor at zero, flush clears.
      always_comb begin
        cnt_nxt_s = cnt_r;
        if (flush) begin
          cnt_nxt_s = CNT_ZERO;
        end else if (hit_alloc_s && !hit_rel_s) begin
          if (cnt_r != CNT_MAX) cnt_nxt_s = cnt_r + CNT_ONE;
          else                  cnt_nxt_s = cnt_r;
        end else if (hit_rel_s && !hit_alloc_s) begin
          if (cnt_r != CNT_ZERO) cnt_nxt_s = cnt_r - CNT_ONE;
          else                   cnt_nxt_s = cnt_r;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end

      // Pending-write counter for this register.
      always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) cnt_r <= CNT_ZERO;
        else         cnt_r <= cnt_nxt_s;
      end

      assign cnt_s[i]      = cnt_r;
      assign busy_nxt_s[i] = (cnt_nxt_s != CNT_ZERO);
    end
  end

  // Issue stall: source hazards plus a full counter on the destination.
  always_comb begin
    sat_s   = issue_long && (issue_rd != 5'd0) && (cnt_s[issue_rd] == CNT_MAX) &&
              !(rel_s && (rel_rd == issue_rd));
    stall_s = 1'b0;
    if (issue_valid && !flush) begin
      stall_s = (use_rj && eff_busy(cnt_s[rj_no], rel_s && (rel_rd == rj_no))) ||
                (use_rk && eff_busy(cnt_s[rk_no], rel_s && (rel_rd == rk_no))) ||
                (use_rd && eff_busy(cnt_s[rd_no], rel_s && (rel_rd == rd_no))) ||
                sat_s;
    end else begin
      stall_s = 1'b0;
    end
  end

  assign underflow_s = rel_s && (cnt_s[rel_rd] == CNT_ZERO) &&
                       !(alloc_s && (issue_rd == rel_rd));

  // Busy mirror, stall-cycle counter and sticky underflow flag.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      busy_vec_r      <= {NREG{1'b0}};
      stall_cycles_r  <= {PERF_W{1'b0}};
      err_underflow_r <= 1'b0;
    end else begin
      busy_vec_r <= busy_nxt_s;
      if (issue_valid && stall_s) stall_cycles_r <= stall_cycles_r + PERF_ONE;
      else                        stall_cycles_r <= stall_cycles_r;
      err_underflow_r <= err_underflow_r || underflow_s;
    end
  end

  assign stall         = stall_s;
  assign busy_vec      = busy_vec_r;
  assign stall_cycles  = stall_cycles_r;
  assign err_underflow = err_underflow_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;

  logic        aclk;
  logic        resetn;
  logic        flush;
  logic        issue_valid;
  logic        issue_fire;
  logic        issue_long;
  logic [4:0]  issue_rd;
  logic        use_rj;
  logic        use_rk;
  logic        use_rd;
  logic [4:0]  rj_no;
  logic [4:0]  rk_no;
  logic [4:0]  rd_no;
  logic        rel_valid;
  logic [4:0]  rel_rd;
  logic        stall;
  logic [31:0] busy_vec;
  logic [31:0] stall_cycles;
  logic        err_underflow;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  reg_scoreboard #(.NREG(32), .CNT_W(2), .PERF_W(32)) dut (
    .aclk(aclk), .resetn(resetn), .flush(flush),
    .issue_valid(issue_valid), .issue_fire(issue_fire), .issue_long(issue_long),
    .issue_rd(issue_rd), .use_rj(use_rj), .use_rk(use_rk), .use_rd(use_rd),
    .rj_no(rj_no), .rk_no(rk_no), .rd_no(rd_no),
    .rel_valid(rel_valid), .rel_rd(rel_rd),
    .stall(stall), .busy_vec(busy_vec), .stall_cycles(stall_cycles),
    .err_underflow(err_underflow)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic idle();
    flush = 1'b0; issue_valid = 1'b0; issue_fire = 1'b0; issue_long = 1'b0;
    issue_rd = 5'd0; use_rj = 1'b0; use_rk = 1'b0; use_rd = 1'b0;
    rj_no = 5'd0; rk_no = 5'd0; rd_no = 5'd0; rel_valid = 1'b0; rel_rd = 5'd0;
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic alloc(input logic [4:0] rd);
    idle();
    issue_valid = 1'b1; issue_fire = 1'b1; issue_long = 1'b1; issue_rd = rd;
  endtask

  task automatic release_reg(input logic [4:0] rd);
    idle();
    rel_valid = 1'b1; rel_rd = rd;
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    #3;
    check_eq("reset_busy", busy_vec, 32'h0);
    check_eq("reset_stall", {31'd0, stall}, 32'd0);
    check_eq("reset_perf", stall_cycles, 32'd0);
    check_eq("reset_err", {31'd0, err_underflow}, 32'd0);
    #4 resetn = 1'b1;
    step();

    // Load-use on r5: three stalled cycles, then bypass in the release cycle.
    alloc(5'd5); #1;
    check_eq("lu_alloc_stall", {31'd0, stall}, 32'd0);
    step();
    check_eq("lu_busy5", busy_vec, 32'h0000_0020);
    idle(); issue_valid = 1'b1; use_rj = 1'b1; rj_no = 5'd5;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("lu_stall", {31'd0, stall}, 32'd1);
      step();
    end
    rel_valid = 1'b1; rel_rd = 5'd5; #1;
    check_eq("lu_rel_bypass", {31'd0, stall}, 32'd0);
    check_eq("lu_perf3", stall_cycles, 32'd3);
    step();
    idle(); #1;
    check_eq("lu_busy_clear", busy_vec, 32'h0);
    check_eq("lu_perf_hold", stall_cycles, 32'd3);

    // Same-cycle alloc+release on r7 keeps the count at 1.
    alloc(5'd7); step();
    check_eq("sc_busy7", busy_vec, 32'h0000_0080);
    alloc(5'd7); rel_valid = 1'b1; rel_rd = 5'd7; step();
    check_eq("sc_busy7_hold", busy_vec, 32'h0000_0080);
    release_reg(5'd7); step();
    check_eq("sc_busy7_clear", busy_vec, 32'h0);
    check_eq("sc_no_err", {31'd0, err_underflow}, 32'd0);

    // Saturation on r9 with CNT_W=2.
    for (int k = 0; k < 3; k++) begin
      alloc(5'd9); #1;
      check_eq("sat_alloc_stall", {31'd0, stall}, 32'd0);
      step();
    end
    idle(); issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9; #1;
    check_eq("sat_full_stall", {31'd0, stall}, 32'd1);
    rel_valid = 1'b1; rel_rd = 5'd9; #1;
    check_eq("sat_rel_bypass", {31'd0, stall}, 32'd0);
    issue_fire = 1'b1; step();
    idle(); issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9; #1;
    check_eq("sat_still_full", {31'd0, stall}, 32'd1);
    idle();
    release_reg(5'd9); step();
    release_reg(5'd9); step();
    check_eq("sat_busy9_after2", busy_vec, 32'h0000_0200);
    release_reg(5'd9); step();
    check_eq("sat_busy9_clear", busy_vec, 32'h0);
    check_eq("sat_no_err", {31'd0, err_underflow}, 32'd0);

    // r0 is never tracked.
    alloc(5'd0); step();
    check_eq("r0_busy", busy_vec, 32'h0);
    idle(); issue_valid = 1'b1; use_rj = 1'b1; rj_no = 5'd0; #1;
    check_eq("r0_stall", {31'd0, stall}, 32'd0);

    // Underflow on r3: flag sets, counter stays at 0 (no wrap).
    release_reg(5'd3); step();
    check_eq("uf_err", {31'd0, err_underflow}, 32'd1);
    check_eq("uf_busy", busy_vec, 32'h0);
    alloc(5'd3); step();
    check_eq("uf_busy3", busy_vec, 32'h0000_0008);
    release_reg(5'd3); step();
    check_eq("uf_cnt_zero", busy_vec, 32'h0);
    check_eq("uf_err_sticky", {31'd0, err_underflow}, 32'd1);

    // Flush with r4=2, r6=1 pending and an alloc to r8 in the flush cycle.
    alloc(5'd4); step();
    alloc(5'd4); step();
    alloc(5'd6); step();
    check_eq("fl_busy_pre", busy_vec, 32'h0000_0050);
    alloc(5'd8); use_rj = 1'b1; rj_no = 5'd4; flush = 1'b1; #1;
    check_eq("fl_stall", {31'd0, stall}, 32'd0);
    step();
    idle(); #1;
    check_eq("fl_busy_post", busy_vec, 32'h0);
    issue_valid = 1'b1; use_rj = 1'b1; rj_no = 5'd8; use_rk = 1'b1; rk_no = 5'd4; #1;
    check_eq("fl_r8_untracked", {31'd0, stall}, 32'd0);
    check_eq("fl_perf_kept", stall_cycles, 32'd3);
    check_eq("fl_err_kept", {31'd0, err_underflow}, 32'd1);

    // Asynchronous reset mid-run with a pending write and an active stall.
    alloc(5'd5); step();
    idle(); issue_valid = 1'b1; use_rd = 1'b1; rd_no = 5'd5; #1;
    check_eq("ar_pre_stall", {31'd0, stall}, 32'd1);
    resetn = 1'b0; #1;
    check_eq("ar_busy", busy_vec, 32'h0);
    check_eq("ar_stall", {31'd0, stall}, 32'd0);
    check_eq("ar_perf", stall_cycles, 32'd0);
    check_eq("ar_err", {31'd0, err_underflow}, 32'd0);
    idle(); #1 resetn = 1'b1;
    step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Per-GPR scoreboard that tracks in-flight long-latency register writes: loads, CSR reads and iterative mul/div.
- Generates the ID-stage issue stall for the pipeline.
- ALU results are forwarded and are never tracked here.
- Sits beside the ID/EX boundary. Its stall output feeds the ID ready_go / IDWriteEn path, and it replaces the comparator-based load-use and CSR hazard terms.

Parameters:
- NREG, 32, number of architectural GPRs; index 0 is hardwired zero.
- CNT_W, 2, width of the per-register pending counter; max in-flight long writes per reg = 2^CNT_W-1.
- PERF_W, 32, width of the stall-cycle performance counter.

Ports:
- aclk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  pipeline-wide flush (exception/ertn/idle at WB); clears all tracking
- issue_valid  in  1  ID holds a valid instruction
- issue_fire  in  1  ID->EX handshake completes this cycle (id valid_out && ex allow_in)
- issue_long  in  1  issuing instruction writes rd via a long-latency path
- issue_rd  in  5  destination register of issuing instruction
- use_rj / use_rk / use_rd  in  1 each  instruction reads rj / rk / rd as a source
- rj_no / rk_no / rd_no  in  5 each  source register numbers in ID
- rel_valid  in  1  a long-latency result becomes forwardable/written this cycle
- rel_rd  in  5  register released
- stall  out  1  ID must not advance (combinational)
- busy_vec  out  NREG  registered: bit i = counter[i] != 0
- stall_cycles  out  PERF_W  cycles with issue_valid && stall
- err_underflow  out  1  sticky: release seen on a zero counter

Behaviour:
- Reset (resetn=0, async): all counters 0, busy_vec=0, stall_cycles=0, err_underflow=0. stall is combinational, so it reads 0 while counters are 0.
- Tracking:
  - alloc = issue_fire && issue_long && issue_rd!=0 && !flush.
  - rel = rel_valid && rel_rd!=0 && !flush.
  - Per register i, on each clock edge:
    - alloc only: +1
    - rel only: -1
    - both: unchanged
    - neither: hold
  - Register 0 is never tracked; busy_vec[0]=0 always.
- effective_busy(r) = counter[r]!=0 && !(rel && rel_rd==r && counter[r]==1). This gives a same-cycle release bypass: the result is on the forward path.
- stall = issue_valid && !flush && ( (use_rj && effective_busy(rj_no)) || (use_rk && effective_busy(rk_no)) || (use_rd && effective_busy(rd_no)) || (issue_long && issue_rd!=0 && counter[issue_rd]==2^CNT_W-1 && !(rel && rel_rd==issue_rd)) ).
- Saturation guard: issue_fire is qualified by !stall upstream, so a counter never exceeds max. If alloc still occurs at max, the counter holds at max (no wrap) and err_underflow is NOT set.
- Underflow: rel on a counter of 0 leaves the counter at 0 and sets err_underflow=1 until reset.
- Flush:
  - Next edge clears all counters to 0; alloc and rel in the flush cycle are ignored.
  - stall=0 during the flush cycle.
  - stall_cycles and err_underflow are unaffected.
- busy_vec: registered copy of (counter!=0), updated the same edge as the counters, so it reflects post-edge state.
- stall_cycles: increments by 1 each cycle issue_valid && stall; wraps modulo 2^PERF_W.
- Latency:
  - A producer allocated at edge N makes its consumer stall from cycle N onward.
  - A release at cycle M lets the dependent issue in cycle M (bypass).
- No internal FSM beyond per-reg counters. Implement the counter array with a generate loop; the three read ports are combinational muxes.

Test Plan:
- Reset and idle:
  - Stimulus: hold resetn=0 mid-run with counters nonzero.
  - Required: busy_vec=0, stall=0 and stall_cycles=0 immediately; no dependency on the clock.
- Load-use:
  - Stimulus: issue long write to r5 (fire). Next cycle issue_valid with use_rj, rj_no=5.
  - Required: stall=1 and busy_vec[5]=1 until rel_valid with rel_rd=5. In the release cycle stall=0. After 3 stalled cycles, stall_cycles=3.
- Same-cycle alloc+release:
  - Stimulus: counter[7]=1; alloc r7 and rel r7 in the same cycle.
  - Required: counter[7] stays 1 and busy_vec[7] stays 1.
- Saturation:
  - Stimulus: CNT_W=2; three long allocs to r9 without release, then a fourth long issue to r9.
  - Required: stall=1 on the fourth issue. If rel r9 arrives that cycle, stall=0 and the counter stays 3.
- r0 and underflow:
  - Stimulus: long alloc to r0, then an instruction with use_rj and rj_no=0.
  - Required: no stall, busy_vec[0]=0.
  - Stimulus: rel r3 while counter[3]=0.
  - Required: err_underflow=1, counter[3]=0.
- Flush:
  - Stimulus: r4=2, r6=1 pending; assert flush together with an alloc to r8.
  - Required: stall=0 that cycle; next cycle busy_vec=0 and r8 is not tracked.
